// File: rtl/sram_pdp_pkg.sv
// -----------------------------------------------------------------------------
// sram_pdp_pkg
// Shared constants and helpers for the pseudo-dual-port SRAM (sram_pdp).
//   DEFAULT_DEPTH : default number of words
//   DEFAULT_WIDTH : default bits per word
//   addr_width()  : address bits needed for a given depth, the same as
//                   $clog2(depth), with a floor of 1 bit
// -----------------------------------------------------------------------------
package sram_pdp_pkg;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_WIDTH = 16;

  // Smallest w with 2**w >= depth_words. It is used in port declarations, so
  // it has to remain a constant function.
  function automatic int addr_width(input int depth_words);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth_words) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_pdp_array.sv
// -----------------------------------------------------------------------------
// sram_pdp_array
// Storage core of sram_pdp. It has one write port and one synchronous read
// port. It contains no reset and no control gating, so that synthesis can map
// it onto a block RAM.
// Ports:
//   clk        : clock, rising edge
//   i_we       : write strobe, already qualified by the top level
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe, already qualified by the top level
//   i_rd_addr  : read address
//   o_rd_data  : registered read data; it holds its value while i_rd_en=0
// On a same-edge read and write to one address, the read returns the old word
// (read-before-write). The reason is that both assignments are nonblocking.
// -----------------------------------------------------------------------------
module sram_pdp_array
  import sram_pdp_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH,
  parameter int width = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [addr_width(depth)-1:0]  i_wr_addr,
  input  logic [width-1:0]              i_wr_data,
  input  logic                          i_rd_en,
  input  logic [addr_width(depth)-1:0]  i_rd_addr,
  output logic [width-1:0]              o_rd_data
);

  logic [width-1:0] r_mem [depth];
  logic [width-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_pdp.sv
// -----------------------------------------------------------------------------
// sram_pdp
// Pseudo-dual-port SRAM. Port A only writes and port B only reads. Both ports
// can be used in the same cycle.
// Ports:
//   clk       : single clock, rising edge
//   rst_n     : asynchronous, active-low reset; clears data_outB only
//   cs        : chip select; gates both ports
//   we_A      : port A write enable
//   add_A     : port A write address
//   data_inA  : port A write data
//   re_B      : port B read enable
//   add_B     : port B read address
//   data_outB : port B read data, one clock of latency; it holds its value
//               while there is no read
// Strobe semantics: an edge performs a write when rst_n & cs & we_A is true,
// and performs a read when rst_n & cs & re_B is true. There is no
// backpressure.
// Reset does not clear the memory contents.
// Optional build macro: SRAM_PDP_BYPASS_EN. When it is defined, a same-edge
// read and write to one address returns the new word (write-first). When it is
// not defined, the read returns the old word.
// -----------------------------------------------------------------------------
module sram_pdp
  import sram_pdp_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH,
  parameter int width = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic                          we_A,
  input  logic [addr_width(depth)-1:0]  add_A,
  input  logic [width-1:0]              data_inA,
  input  logic                          re_B,
  input  logic [addr_width(depth)-1:0]  add_B,
  output logic [width-1:0]              data_outB
);

  logic             w_wr_en;
  logic             w_rd_en;
  logic [width-1:0] w_arr_rd_data;
  logic             r_out_clr;

  // The array has no reset. rst_n is used here as a gate so that neither port
  // has any effect while reset is held, including on the edge where reset
  // asserts.
  assign w_wr_en = rst_n & cs & we_A;
  assign w_rd_en = rst_n & cs & re_B;

  sram_pdp_array #(
    .depth (depth),
    .width (width)
  ) u_array (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_wr_addr (add_A),
    .i_wr_data (data_inA),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (add_B),
    .o_rd_data (w_arr_rd_data)
  );

  // The array's read register cannot be reset. Reset therefore sets this flag,
  // and the flag forces the output to zero at once. The flag stays set until
  // the first real read after reset, so the output holds 0 until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_clr <= 1'b1;
    end else if (w_rd_en) begin
      r_out_clr <= 1'b0;
    end
  end

`ifdef SRAM_PDP_BYPASS_EN
  logic             w_collide;
  logic             r_byp_sel;
  logic [width-1:0] r_byp_data;

  assign w_collide = w_wr_en & w_rd_en & (add_A == add_B);

  // On a collision, capture the incoming write word. Any later read that is
  // not a collision drops the forwarded word, and the output then follows the
  // array again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else if (w_rd_en) begin
      r_byp_sel <= w_collide;
      if (w_collide) begin
        r_byp_data <= data_inA;
      end
    end
  end

  assign data_outB = r_out_clr ? '0 : (r_byp_sel ? r_byp_data : w_arr_rd_data);
`else
  assign data_outB = r_out_clr ? '0 : w_arr_rd_data;
`endif

endmodule

// File: tb/tb_sram_pdp.sv
module tb_sram_pdp;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 16;
  localparam int AW    = 10;

  logic             clk;
  logic             rst_n;
  logic             cs;
  logic             we_A;
  logic [AW-1:0]    add_A;
  logic [WIDTH-1:0] data_inA;
  logic             re_B;
  logic [AW-1:0]    add_B;
  logic [WIDTH-1:0] data_outB;

  sram_pdp #(
    .depth (DEPTH),
    .width (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .we_A      (we_A),
    .add_A     (add_A),
    .data_inA  (data_inA),
    .re_B      (re_B),
    .add_B     (add_B),
    .data_outB (data_outB)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic             cs;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             re;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic c, input logic w, input int wa, input int wd,
                         input logic r, input int ra, input int e);
    vec_t v;
    v.cs  = c;
    v.we  = w;
    v.wa  = AW'(wa);
    v.wd  = WIDTH'(wd);
    v.re  = r;
    v.ra  = AW'(ra);
    v.exp = WIDTH'(e);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data_outB=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one edge: the inputs change on the falling edge, and data_outB is
  // sampled #1 after the rising edge.
  task automatic drive_cycle(input logic c, input logic w, input logic [AW-1:0] wa,
                             input logic [WIDTH-1:0] wd, input logic r,
                             input logic [AW-1:0] ra, input logic [WIDTH-1:0] e,
                             input string name);
    logic [WIDTH-1:0] exp_v;
    @(negedge clk);
    cs       = c;
    we_A     = w;
    add_A    = wa;
    data_inA = wd;
    re_B     = r;
    add_B    = ra;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      check(name, data_outB, exp_v);
    end
  endtask

  logic [WIDTH-1:0] collide_exp;

  initial begin
`ifdef SRAM_PDP_BYPASS_EN
    collide_exp = 16'hAAAA;
`else
    collide_exp = 16'h0F0F;
`endif
    // Inputs are: cs, we, wa, wd, re, ra. The last value is data_outB after
    // the edge.
    add_vec(1, 1,   12, 'hABCD, 0,    0, 'h0000); // write only, output stays at reset value
    add_vec(1, 1,  100, 'h1234, 1,   12, 'hABCD); // read 12 and write 100, different addresses
    add_vec(1, 0,    0, 'h0000, 1,  100, 'h1234);
    add_vec(1, 0,    0, 'h0000, 1,   12, 'hABCD);
    add_vec(0, 1,   12, 'h5555, 1,  100, 'hABCD); // cs=0: write blocked, output holds
    add_vec(1, 0,    0, 'h0000, 1,  100, 'h1234);
    add_vec(1, 0,    0, 'h0000, 1,   12, 'hABCD); // the blocked write left 12 unchanged
    add_vec(1, 1,    0, 'h0001, 0,    0, 'hABCD);
    add_vec(1, 1, 1023, 'hFFFF, 0,    0, 'hABCD);
    add_vec(1, 1,  511, 'h7777, 0,    0, 'hABCD);
    add_vec(1, 1,    5, 'h0F0F, 1,    0, 'h0001); // low address boundary
    add_vec(1, 0,    0, 'h0000, 1, 1023, 'hFFFF); // top address, not aliased with 511
    add_vec(1, 0,    0, 'h0000, 1,  511, 'h7777);
    add_vec(1, 0,    0, 'h0000, 1,    5, 'h0F0F);
    add_vec(1, 1,    5, 'hAAAA, 1,    5, collide_exp); // same-address collision
    add_vec(1, 0,    0, 'h0000, 1,    5, 'hAAAA);
    add_vec(1, 0,    0, 'h0000, 0,   12, 'hAAAA); // re_B=0 while add_B changes
    add_vec(1, 0,    0, 'h0000, 0,  100, 'hAAAA);
    add_vec(1, 0,    0, 'h0000, 0, 1023, 'hAAAA);
    add_vec(0, 0,    0, 'h0000, 1,   12, 'hAAAA); // cs=0 blocks the read

    cs = 0; we_A = 0; add_A = '0; data_inA = '0; re_B = 0; add_B = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", data_outB, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].cs, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re, vecs[i].ra, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset pulsed mid-cycle: the output must clear before the next edge.
    drive_cycle(1, 0, '0, '0, 1, AW'(100), 16'h1234, "pre_reset_read");
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", data_outB, '0);
    // This write and read happen while reset is held and must both be dropped.
    drive_cycle(1, 1, AW'(100), 16'hDEAD, 1, AW'(100), 16'h0000, "in_reset_ignored");
    #2;
    rst_n = 1'b1;
    drive_cycle(1, 0, '0, '0, 0, AW'(12), 16'h0000, "post_reset_hold");
    drive_cycle(1, 0, '0, '0, 1, AW'(100), 16'h1234, "post_reset_retained");
    drive_cycle(1, 0, '0, '0, 1, AW'(12), 16'hABCD, "post_reset_read12");

    // Random traffic on addresses that are already known; the expected values
    // come from a bench-side model.
    begin
      logic [WIDTH-1:0] model [int];
      logic [WIDTH-1:0] last;
      int addrs[4];
      addrs[0] = 12; addrs[1] = 100; addrs[2] = 1023; addrs[3] = 0;
      model[12] = 16'hABCD; model[100] = 16'h1234; model[1023] = 16'hFFFF; model[0] = 16'h0001;
      last = 16'hABCD;
      for (int k = 0; k < 40; k++) begin
        logic c, w, r;
        int wa, ra;
        logic [WIDTH-1:0] wd, e;
        c  = ($urandom_range(0, 7) != 0);
        w  = $urandom_range(0, 1);
        r  = $urandom_range(0, 1);
        wa = addrs[$urandom_range(0, 3)];
        ra = addrs[$urandom_range(0, 3)];
        wd = WIDTH'($urandom_range(0, 65535));
        e  = last;
        if (c && r) begin
`ifdef SRAM_PDP_BYPASS_EN
          e = (w && wa == ra) ? wd : model[ra];
`else
          e = model[ra];
`endif
        end
        if (c && w) model[wa] = wd;
        last = e;
        drive_cycle(c, w, AW'(wa), wd, r, AW'(ra), e, $sformatf("rand%0d", k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_pdp.md
SRAM_PDP -- requirements
Module: sram_pdp

Interface
REQ-001 Parameter depth, default 1024, number of words; SHALL be a power of two, at least 2.
REQ-002 Parameter width, default 16, bits per word; SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cs  input  1  chip select; gates both ports.
REQ-006 we_A  input  1  port A write enable.
REQ-007 add_A  input  $clog2(depth)  port A write address.
REQ-008 data_inA  input  width  port A write data.
REQ-009 re_B  input  1  port B read enable.
REQ-010 add_B  input  $clog2(depth)  port B read address.
REQ-011 data_outB  output  width  port B registered read data.

Function
REQ-012 Storage SHALL be a depth x width array; port A is write-only and port B is read-only, with both usable in the same cycle.
REQ-013 Write: at a rising edge with rst_n=1, cs=1 and we_A=1, mem[add_A] SHALL be loaded with data_inA.
REQ-014 Read: at a rising edge with rst_n=1, cs=1 and re_B=1, data_outB SHALL be loaded with mem[add_B]; latency is one clock.
REQ-015 data_outB SHALL hold its last value whenever cs=0 or re_B=0.
REQ-016 cs=0 SHALL block writes, leaving memory unchanged, regardless of we_A.
REQ-017 Same-edge read and write to different addresses SHALL both complete independently.
REQ-018 Same-edge read and write to the same address, without SRAM_PDP_BYPASS_EN: data_outB SHALL return the old stored word (read-before-write), and the memory SHALL take the new word.
REQ-019 Reading a never-written address SHALL return unspecified data; the bench SHALL NOT check it.
REQ-020 Addresses SHALL cover the full range 0 to depth-1 with no wrap or aliasing, because depth is a power of two.

Reset
REQ-021 When rst_n=0, data_outB SHALL clear to 0 immediately, independent of clk.
REQ-022 Memory contents SHALL NOT be affected by reset; words written before reset SHALL remain readable after it.
REQ-023 While rst_n=0, writes and reads SHALL be ignored.
REQ-024 If reset asserts in the same cycle as a write, that write SHALL be dropped.
REQ-025 Operation SHALL resume at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro SRAM_PDP_BYPASS_EN, when defined, SHALL enable write-through forwarding: on a same-edge read and write to the same address with cs=1, data_outB SHALL be loaded with data_inA (write-first).
REQ-027 Without SRAM_PDP_BYPASS_EN, REQ-018 applies and no forwarding logic SHALL be synthesized.

Structure
REQ-028 Package sram_pdp_pkg SHALL hold the default depth and width constants and an address-width helper, the equivalent of $clog2(depth).
REQ-029 Sub-module sram_pdp_array SHALL hold the storage array, with one write port and one synchronous read port.
REQ-030 sram_pdp SHALL hold the control gating, the bypass compare/mux and the reset of the output register.

Verification
REQ-031 cs=1, we_A=1, add_A=12, data_inA=16'hABCD for one edge; then re_B=1, add_B=12 -> data_outB=16'hABCD one edge after the read edge.
REQ-032 Write 16'h1234 to 100, then read 100 -> data_outB=16'h1234; reading 12 again -> 16'hABCD.
REQ-033 cs=0, we_A=1, add_A=12, data_inA=16'h5555; then cs=1 read 12 -> data_outB=16'hABCD, so the write was blocked.
REQ-034 mem[5]=16'h0F0F already stored; same edge: write 16'hAAAA to 5 and read 5 -> data_outB=16'h0F0F without the macro, 16'hAAAA with SRAM_PDP_BYPASS_EN; next read of 5 -> 16'hAAAA in both builds.
REQ-035 data_outB=16'h1234, then pulse rst_n=0 mid-cycle -> data_outB=0 before the next edge; after release, read 100 -> 16'h1234, so memory was retained.
REQ-036 re_B=0 for several edges while add_B changes -> data_outB unchanged.
